// File: rtl/stm_reader.sv
// stm_reader: capture-side reader for the two-phase A/B producer stream.
// A local phase tracker toggles every cycle out of reset. Enabled words are
// tagged with that phase and queued in a small circular FIFO that a consumer
// drains over valid/ready. Words that arrive while the FIFO is full are dropped
// and counted in a saturating counter.
module stm_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_en,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_phase,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           drop_count,
  output logic                       phase
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Each entry holds the phase tag in the MSB above the data word.
  logic [WIDTH:0]       mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  logic                 pop;
  logic                 full;
  logic                 do_push;
  logic                 drop;
  logic [LVL_W-1:0]     level_n;
  logic [LVL_W-1:0]     remain;
  logic [PTR_W-1:0]     rd_ptr_n;
  logic [WIDTH:0]       head_n;

  // Next-state decode; the head registers are loaded from the entry that will be at the front after this edge.
  always_comb begin
    pop      = out_valid && out_ready;
    full     = (level == LVL_W'(DEPTH));
    do_push  = in_en && (!full || pop);
    drop     = in_en && full && !pop;
    level_n  = level + LVL_W'(do_push) - LVL_W'(pop);
    remain   = level - LVL_W'(pop);
    rd_ptr_n = rd_ptr + PTR_W'(pop);
    head_n   = {out_phase, out_data};
    if (remain == '0) begin
      if (do_push) begin
        head_n = {phase, in_data};
      end
    end else begin
      head_n = mem[rd_ptr_n];
    end
  end

  // FIFO storage; contents are don't-care after reset so it carries no reset term.
  always_ff @(posedge CLK) begin
    if (RST_N && do_push) begin
      mem[wr_ptr] <= {phase, in_data};
    end
  end

  // Control state, phase tracker, registered head outputs and the saturating drop counter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      phase      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_phase  <= 1'b0;
      drop_count <= '0;
    end else begin
      phase     <= ~phase;
      wr_ptr    <= wr_ptr + PTR_W'(do_push);
      rd_ptr    <= rd_ptr_n;
      level     <= level_n;
      out_valid <= (level_n != '0);
      out_phase <= head_n[WIDTH];
      out_data  <= head_n[WIDTH-1:0];
      if (drop && (drop_count != {CNT_W{1'b1}})) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stm_reader.sv
// tb_stm_reader: directed self-checking bench for stm_reader.
// A default-sized instance and a CNT_W=2 instance share every input so the
// drop counter saturation can be observed alongside the wide counter.
module tb_stm_reader;

  logic        CLK;
  logic        RST_N;
  logic [31:0] in_data;
  logic        in_en;
  logic        out_ready;

  logic        out_valid;
  logic [31:0] out_data;
  logic        out_phase;
  logic [2:0]  level;
  logic [15:0] drop_count;
  logic        phase;

  logic        out_valid_s;
  logic [31:0] out_data_s;
  logic        out_phase_s;
  logic [2:0]  level_s;
  logic [1:0]  drop_count_s;
  logic        phase_s;

  int checks;
  int errors;
  logic exp_phase;

  stm_reader #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .in_data    (in_data),
    .in_en      (in_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_phase  (out_phase),
    .out_ready  (out_ready),
    .level      (level),
    .drop_count (drop_count),
    .phase      (phase)
  );

  stm_reader #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut_sat (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .in_data    (in_data),
    .in_en      (in_en),
    .out_valid  (out_valid_s),
    .out_data   (out_data_s),
    .out_phase  (out_phase_s),
    .out_ready  (out_ready),
    .level      (level_s),
    .drop_count (drop_count_s),
    .phase      (phase_s)
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drive one cycle of inputs, take the edge, and advance the phase model.
  task automatic applyStimulus(input logic en, input logic [31:0] data, input logic ready);
    in_en     = en;
    in_data   = data;
    out_ready = ready;
    @(posedge CLK);
    #1;
    if (RST_N) exp_phase = ~exp_phase;
    else       exp_phase = 1'b0;
  endtask

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed test sequence.
  initial begin
    logic [31:0] exp_words [4];
    logic        exp_tags  [4];
    checks    = 0;
    errors    = 0;
    exp_phase = 1'b0;
    RST_N     = 1'b0;
    in_en     = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("rst_phase", 32'(phase), 32'h0);
    checkOutput("rst_level", 32'(level), 32'h0);
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_data", out_data, 32'h0);
    checkOutput("rst_ophase", 32'(out_phase), 32'h0);
    checkOutput("rst_drops", 32'(drop_count), 32'h0);

    // Idle: phase toggles 0,1,0,1,0,1 and nothing is queued
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput("idle_phase", 32'(phase), 32'(i % 2));
      checkOutput("idle_model_phase", 32'(phase), 32'(exp_phase));
      applyStimulus(1'b0, 32'h0, 1'b0);
    end
    checkOutput("idle_valid", 32'(out_valid), 32'h0);
    checkOutput("idle_level", 32'(level), 32'h0);
    checkOutput("idle_drops", 32'(drop_count), 32'h0);

    // Single word with one-cycle latency, then immediately popped
    checkOutput("single_phase0", 32'(phase), 32'h0);
    applyStimulus(1'b1, 32'h0000_00A5, 1'b1);
    checkOutput("single_valid", 32'(out_valid), 32'h1);
    checkOutput("single_data", out_data, 32'h0000_00A5);
    checkOutput("single_ophase", 32'(out_phase), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("single_empty", 32'(out_valid), 32'h0);
    checkOutput("single_level", 32'(level), 32'h0);

    // Overflow: four words fill the FIFO, two more are dropped
    checkOutput("ovf_phase0", 32'(phase), 32'h0);
    for (int k = 1; k <= 6; k++) applyStimulus(1'b1, 32'(k), 1'b0);
    checkOutput("ovf_level", 32'(level), 32'h4);
    checkOutput("ovf_drops", 32'(drop_count), 32'h2);
    checkOutput("ovf_head", out_data, 32'h1);
    checkOutput("ovf_hold_valid", 32'(out_valid), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("ovf_drain_valid", 32'(out_valid), 32'h1);
      checkOutput("ovf_drain_data", out_data, 32'(k));
      checkOutput("ovf_drain_tag", 32'(out_phase), 32'((k - 1) % 2));
      applyStimulus(1'b0, 32'h0, 1'b1);
    end
    checkOutput("ovf_empty", 32'(out_valid), 32'h0);
    checkOutput("ovf_empty_level", 32'(level), 32'h0);

    // Full FIFO with simultaneous push and pop: no drops, level stays 4
    checkOutput("fullpp_phase0", 32'(phase), 32'h0);
    for (int k = 1; k <= 4; k++) applyStimulus(1'b1, 32'(k), 1'b0);
    checkOutput("fullpp_level_pre", 32'(level), 32'h4);
    for (int k = 7; k <= 9; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b1);
      checkOutput("fullpp_level", 32'(level), 32'h4);
      checkOutput("fullpp_drops", 32'(drop_count), 32'h2);
      checkOutput("fullpp_head", out_data, 32'(k - 5));
    end
    exp_words[0] = 32'h4; exp_tags[0] = 1'b1;
    exp_words[1] = 32'h7; exp_tags[1] = 1'b0;
    exp_words[2] = 32'h8; exp_tags[2] = 1'b1;
    exp_words[3] = 32'h9; exp_tags[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("fullpp_drain_valid", 32'(out_valid), 32'h1);
      checkOutput("fullpp_drain_data", out_data, exp_words[k]);
      checkOutput("fullpp_drain_tag", 32'(out_phase), 32'(exp_tags[k]));
      applyStimulus(1'b0, 32'h0, 1'b1);
    end
    checkOutput("fullpp_empty", 32'(out_valid), 32'h0);

    // Mid-stream reset with in_en and out_ready high discards everything
    applyStimulus(1'b1, 32'h11, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0);
    checkOutput("mrst_level_pre", 32'(level), 32'h2);
    RST_N = 1'b0;
    applyStimulus(1'b1, 32'h99, 1'b1);
    checkOutput("mrst_level", 32'(level), 32'h0);
    checkOutput("mrst_valid", 32'(out_valid), 32'h0);
    checkOutput("mrst_phase", 32'(phase), 32'h0);
    checkOutput("mrst_drops", 32'(drop_count), 32'h0);
    checkOutput("mrst_data", out_data, 32'h0);
    RST_N = 1'b1;
    applyStimulus(1'b1, 32'h33, 1'b0);
    checkOutput("mrst_restart_valid", 32'(out_valid), 32'h1);
    checkOutput("mrst_restart_data", out_data, 32'h33);
    checkOutput("mrst_restart_tag", 32'(out_phase), 32'h0);
    checkOutput("mrst_restart_level", 32'(level), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mrst_restart_drain", 32'(level), 32'h0);
    checkOutput("mrst_model_phase", 32'(phase), 32'(exp_phase));

    // Drop counter saturation on the narrow instance, plain counting on the wide one
    RST_N = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    RST_N = 1'b1;
    checkOutput("sat_rst_drops", 32'(drop_count_s), 32'h0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'(16 + k), 1'b0);
    checkOutput("sat_level", 32'(level_s), 32'h4);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 32'(32 + k), 1'b0);
      checkOutput("sat_drops", 32'(drop_count_s), (k < 3) ? 32'(k) : 32'h3);
      checkOutput("wide_drops", 32'(drop_count), 32'(k));
      checkOutput("sat_head_hold", out_data_s, 32'd16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
